multicycle_cu: RTL and testbench

- Multi-cycle LEGv8 control unit: FSM sequences FETCH/DECODE/EXEC/MEM/WB over a shared datapath instead of one-cycle combinational decode.
- Adds instruction/data memory wait handshake, PC and IR write enables, and correct conditional-branch resolution for CBZ and CBNZ.
- Sits between the instruction register (opcode source) and the datapath muxes, register file, ALU and memory interface.

---
 rtl/cu_pkg.sv | 70 +++++++
 rtl/cu_decode.sv | 32 +++
 rtl/multicycle_cu.sv | 141 ++++++++++++++
 tb/tb_multicycle_cu.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared types and encodings for the multi-cycle LEGv8 control unit:
// FSM states, instruction classes, opcode match prefixes and control bundle.
package cu_pkg;

   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

   typedef enum logic [3:0] {
      C_NOP, C_ADD, C_SUB, C_AND, C_ORR, C_LDUR, C_STUR,
      C_ADDI, C_SUBI, C_ANDI, C_ORRI, C_CBZ, C_CBNZ, C_B
   } cls_t;

   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [9:0]  OP_ADDI = 10'b1001000100;
   localparam logic [9:0]  OP_SUBI = 10'b1101000100;
   localparam logic [9:0]  OP_ANDI = 10'b1001001000;
   localparam logic [9:0]  OP_ORRI = 10'b1011001000;
   localparam logic [7:0]  OP_CBZ  = 8'b10110100;
   localparam logic [7:0]  OP_CBNZ = 8'b10110101;
   localparam logic [5:0]  OP_B    = 6'b000101;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_AND  = 3'b010;
   localparam logic [2:0] ALU_ORR  = 3'b011;
   localparam logic [2:0] ALU_PASS = 3'b100;

   localparam logic [1:0] SEU_ALU = 2'b00;
   localparam logic [1:0] SEU_D   = 2'b01;
   localparam logic [1:0] SEU_B   = 2'b10;
   localparam logic [1:0] SEU_CB  = 2'b11;

   typedef struct packed {
      logic       pcWr;
      logic       irWr;
      logic       reg2loc;
      logic [1:0] seu;
      logic       aluSrc;
      logic [2:0] aluOp;
      logic       memRd;
      logic       memWr;
      logic       memToReg;
      logic       regWr;
      logic       pcSrc;
      logic       trap;
   } ctrl_t;

   // ALU operand/function setup for a class; MEM and WB re-use it to hold EXEC values.
   function automatic ctrl_t aluCtl(cls_t c);
      ctrl_t r;
      r = '0;
      case (c)
         C_SUB:  r.aluOp = ALU_SUB;
         C_AND:  r.aluOp = ALU_AND;
         C_ORR:  r.aluOp = ALU_ORR;
         C_ADDI: r.aluSrc = 1'b1;
         C_SUBI: begin r.aluSrc = 1'b1; r.aluOp = ALU_SUB; end
         C_ANDI: begin r.aluSrc = 1'b1; r.aluOp = ALU_AND; end
         C_ORRI: begin r.aluSrc = 1'b1; r.aluOp = ALU_ORR; end
         C_LDUR, C_STUR: begin r.aluSrc = 1'b1; r.seu = SEU_D; end
         default: ;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational opcode-to-class priority decoder: full 11-bit matches first,
// then the I-type, CB-type and B-type prefixes.
module cu_decode
   import cu_pkg::*;
#(
   parameter int OPCODE_W = 11
) (
   input  logic [OPCODE_W-1:0] opcode,
   output cls_t                cls
);

   logic [10:0] op;
   assign op = opcode[OPCODE_W-1 -: 11];

   always_comb begin
      cls = C_NOP;
      if      (op == OP_ADD)       cls = C_ADD;
      else if (op == OP_SUB)       cls = C_SUB;
      else if (op == OP_AND)       cls = C_AND;
      else if (op == OP_ORR)       cls = C_ORR;
      else if (op == OP_LDUR)      cls = C_LDUR;
      else if (op == OP_STUR)      cls = C_STUR;
      else if (op[10:1] == OP_ADDI) cls = C_ADDI;
      else if (op[10:1] == OP_SUBI) cls = C_SUBI;
      else if (op[10:1] == OP_ANDI) cls = C_ANDI;
      else if (op[10:1] == OP_ORRI) cls = C_ORRI;
      else if (op[10:3] == OP_CBZ)  cls = C_CBZ;
      else if (op[10:3] == OP_CBNZ) cls = C_CBNZ;
      else if (op[10:5] == OP_B)    cls = C_B;
   end

endmodule

// File: rtl/multicycle_cu.sv
// Multi-cycle LEGv8 control unit (FETCH/DECODE/EXEC/MEM/WB) with memory wait handshake.
// Define ILLEGAL_TRAP_EN to send unknown opcodes to a sticky TRAP state.
module multicycle_cu
   import cu_pkg::*;
#(
   parameter int OPCODE_W = 11,
   parameter int ALUOP_W  = 3,
   parameter int SEU_W    = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                zero,
   input  logic                mem_ready,
   output logic                pc_wr,
   output logic                ir_wr,
   output logic                reg2loc,
   output logic [SEU_W-1:0]    seu,
   output logic                alu_src,
   output logic [ALUOP_W-1:0]  alu_op,
   output logic                mem_rd,
   output logic                mem_wr,
   output logic                mem_to_reg,
   output logic                reg_wr,
   output logic                pc_src,
   output logic                trap
);

   state_t state, stateNxt;
   cls_t   cls, decCls;
   ctrl_t  o;
   logic   taken;

   cu_decode #(.OPCODE_W(OPCODE_W)) uDecode (
      .opcode (opcode),
      .cls    (decCls)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= FETCH;
         cls   <= C_NOP;
      end else begin
         state <= stateNxt;
         if (state == DECODE) cls <= decCls;
      end
   end

   always_comb begin
      stateNxt = state;
      o        = '0;
      taken    = (cls == C_CBZ) ? zero : !zero;
      case (state)
         FETCH: begin
            o.memRd = 1'b1;
            if (mem_ready) begin
               o.irWr   = 1'b1;
               o.pcWr   = 1'b1;
               stateNxt = DECODE;
            end
         end
         DECODE: begin
            o.reg2loc = (decCls inside {C_STUR, C_CBZ, C_CBNZ});
            if (decCls == C_NOP)
`ifdef ILLEGAL_TRAP_EN
               stateNxt = TRAP;
`else
               stateNxt = FETCH;
`endif
            else
               stateNxt = EXEC;
         end
         EXEC: begin
            stateNxt = FETCH;
            case (cls)
               C_B: begin
                  o.seu  = SEU_B;
                  o.pcSrc = 1'b1;
                  o.pcWr  = 1'b1;
               end
               C_CBZ, C_CBNZ: begin
                  o.reg2loc = 1'b1;
                  o.seu     = SEU_CB;
                  o.aluOp   = ALU_PASS;
                  o.pcSrc   = taken;
                  o.pcWr    = taken;
               end
               C_LDUR, C_STUR: begin
                  o         = aluCtl(cls);
                  o.reg2loc = (cls == C_STUR);
                  stateNxt  = MEM;
               end
               C_NOP: ;
               default: begin
                  o        = aluCtl(cls);
                  stateNxt = WB;
               end
            endcase
         end
         MEM: begin
            // Address stays on the ALU for the whole access, including wait cycles.
            o = aluCtl(cls);
            if (cls == C_LDUR) o.memRd = 1'b1;
            else begin
               o.memWr   = 1'b1;
               o.reg2loc = 1'b1;
            end
            if (mem_ready) stateNxt = (cls == C_LDUR) ? WB : FETCH;
         end
         WB: begin
            o          = aluCtl(cls);
            o.regWr    = 1'b1;
            o.memToReg = (cls == C_LDUR);
            stateNxt   = FETCH;
         end
         TRAP: begin
`ifdef ILLEGAL_TRAP_EN
            o.trap = 1'b1;
`else
            stateNxt = FETCH;
`endif
         end
         default: stateNxt = FETCH;
      endcase
      if (rst) o = '0;
   end

   assign pc_wr      = o.pcWr;
   assign ir_wr      = o.irWr;
   assign reg2loc    = o.reg2loc;
   assign seu        = SEU_W'(o.seu);
   assign alu_src    = o.aluSrc;
   assign alu_op     = ALUOP_W'(o.aluOp);
   assign mem_rd     = o.memRd;
   assign mem_wr     = o.memWr;
   assign mem_to_reg = o.memToReg;
   assign reg_wr     = o.regWr;
   assign pc_src     = o.pcSrc;
   assign trap       = o.trap;

endmodule

// File: tb/tb_multicycle_cu.sv
// Bench for multicycle_cu: directed vector table, hand-written corner sequences,
// and random instruction streams checked against a phase-list reference model.
module tb_multicycle_cu;

   logic        clk = 1'b0;
   logic        rst;
   logic [10:0] opcode;
   logic        zero, mem_ready;
   logic        pc_wr, ir_wr, reg2loc, alu_src, mem_rd, mem_wr, mem_to_reg, reg_wr, pc_src, trap;
   logic [1:0]  seu;
   logic [2:0]  alu_op;

   multicycle_cu dut (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .pc_wr(pc_wr), .ir_wr(ir_wr), .reg2loc(reg2loc), .seu(seu), .alu_src(alu_src),
      .alu_op(alu_op), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_to_reg(mem_to_reg),
      .reg_wr(reg_wr), .pc_src(pc_src), .trap(trap)
   );

   always #5 clk = ~clk;

   logic [14:0] act;
   assign act = {pc_wr, ir_wr, reg2loc, seu, alu_src, alu_op, mem_rd, mem_wr,
                 mem_to_reg, reg_wr, pc_src, trap};

   localparam logic [14:0] PCWR = 15'h4000, IRWR = 15'h2000, R2L = 15'h1000;
   localparam logic [14:0] ASRC = 15'h0200, MRD = 15'h0020, MWR = 15'h0010;
   localparam logic [14:0] M2R = 15'h0008, RW = 15'h0004, PSRC = 15'h0002, TRP = 15'h0001;

   function automatic logic [14:0] seuF(int v); return 15'(v << 10); endfunction
   function automatic logic [14:0] aopF(int v); return 15'(v << 6);  endfunction

   localparam int K_NOP = 0, K_ADD = 1, K_SUB = 2, K_AND = 3, K_ORR = 4, K_LDUR = 5, K_STUR = 6;
   localparam int K_ADDI = 7, K_SUBI = 8, K_ANDI = 9, K_ORRI = 10, K_CBZ = 11, K_CBNZ = 12, K_B = 13;
   localparam int PF = 0, PD = 1, PE = 2, PM = 3, PW = 4, PT = 5;

   typedef int iq_t[$];

   int nChecks = 0, nPass = 0;

   // Reference model: instruction kind by first-match wildcard table.
   function automatic int classify(logic [10:0] op);
      casez (op)
         11'b10001011000: return K_ADD;
         11'b11001011000: return K_SUB;
         11'b10001010000: return K_AND;
         11'b10101010000: return K_ORR;
         11'b11111000010: return K_LDUR;
         11'b11111000000: return K_STUR;
         11'b1001000100?: return K_ADDI;
         11'b1101000100?: return K_SUBI;
         11'b1001001000?: return K_ANDI;
         11'b1011001000?: return K_ORRI;
         11'b10110100???: return K_CBZ;
         11'b10110101???: return K_CBNZ;
         11'b000101?????: return K_B;
         default:         return K_NOP;
      endcase
   endfunction

   function automatic iq_t phases(int k);
      case (k)
         K_NOP:             return '{PF, PD};
         K_B, K_CBZ, K_CBNZ: return '{PF, PD, PE};
         K_LDUR:            return '{PF, PD, PE, PM, PW};
         K_STUR:            return '{PF, PD, PE, PM};
         default:           return '{PF, PD, PE, PW};
      endcase
   endfunction

   function automatic int opOf(int k);
      case (k)
         K_SUB, K_SUBI: return 1;
         K_AND, K_ANDI: return 2;
         K_ORR, K_ORRI: return 3;
         default:       return 0;
      endcase
   endfunction

   function automatic logic [14:0] expOut(int p, int k, logic z, logic rdy);
      logic        imm, mem, t;
      logic [14:0] alu;
      imm = k inside {K_ADDI, K_SUBI, K_ANDI, K_ORRI};
      mem = k inside {K_LDUR, K_STUR};
      alu = ((imm || mem) ? ASRC : 15'd0) | seuF(mem ? 1 : 0) | aopF(opOf(k));
      t   = (k == K_CBZ) ? z : !z;
      case (p)
         PF: return MRD | (rdy ? (IRWR | PCWR) : 15'd0);
         PD: return (k inside {K_STUR, K_CBZ, K_CBNZ}) ? R2L : 15'd0;
         PE: begin
            if (k == K_B) return seuF(2) | PSRC | PCWR;
            if (k == K_CBZ || k == K_CBNZ)
               return R2L | seuF(3) | aopF(4) | (t ? (PSRC | PCWR) : 15'd0);
            return alu | ((k == K_STUR) ? R2L : 15'd0);
         end
         PM: return alu | ((k == K_LDUR) ? MRD : (MWR | R2L));
         PW: return alu | RW | ((k == K_LDUR) ? M2R : 15'd0);
         default: return TRP;
      endcase
   endfunction

   task automatic chk(input logic [14:0] got, input logic [14:0] exp, input string nm);
      nChecks++;
      if (got === exp) nPass++;
      else $display("FAIL %s: got %b expected %b", nm, got, exp);
   endtask

   // Inputs already driven by the caller just after the rising edge.
   task automatic step(input logic [14:0] exp, input string nm);
      #2;
      chk(act, exp, nm);
      @(posedge clk); #1;
   endtask

   // Run one instruction through the model's phase list; -1 waits mean random.
   task automatic runInstr(input logic [10:0] op, input int fetchWait, input int memWait,
                           input string tag);
      iq_t  seq;
      int   k, waits;
      logic rdy, z;
      k   = classify(op);
      seq = phases(k);
      foreach (seq[i]) begin
         waits = (seq[i] == PF) ? fetchWait : (seq[i] == PM) ? memWait : 0;
         if (waits < 0) waits = $urandom_range(0, 3);
         for (int w = 0; w <= waits; w++) begin
            rdy = (w == waits);
            if (seq[i] != PF && seq[i] != PM) rdy = 1'($urandom);
            z         = 1'($urandom);
            mem_ready = rdy;
            zero      = z;
            opcode    = (seq[i] == PD) ? op : 11'($urandom);
            step(expOut(seq[i], k, z, rdy), $sformatf("%s_ph%0d_c%0d", tag, seq[i], w));
         end
      end
   endtask

   typedef struct {
      logic [10:0] op;
      logic        z;
      int          len;
      logic [14:0] ex;
      string       nm;
   } vec_t;

   vec_t        tbl[$];
   logic [10:0] base[14] = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000,
                             11'b11111000010, 11'b11111000000, 11'b10010001000, 11'b11010001000,
                             11'b10010010000, 11'b10110010000, 11'b10110100000, 11'b10110101000,
                             11'b00010100000, 11'b00000000000};
   int          freeBits[14] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 3, 3, 5, 11};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int          len, capIdx, j;
      logic [14:0] cap;
      logic [10:0] op;

      tbl.push_back('{11'b10001011000, 1'b0, 4, 15'd0,                                "add"});
      tbl.push_back('{11'b11001011000, 1'b1, 4, aopF(1),                              "sub"});
      tbl.push_back('{11'b10001010000, 1'b0, 4, aopF(2),                              "and"});
      tbl.push_back('{11'b10101010000, 1'b0, 4, aopF(3),                              "orr"});
      tbl.push_back('{11'b10010001001, 1'b0, 4, ASRC,                                 "addi"});
      tbl.push_back('{11'b11010001000, 1'b0, 4, ASRC | aopF(1),                       "subi"});
      tbl.push_back('{11'b10010010000, 1'b1, 4, ASRC | aopF(2),                       "andi"});
      tbl.push_back('{11'b10110010001, 1'b0, 4, ASRC | aopF(3),                       "orri"});
      tbl.push_back('{11'b11111000010, 1'b0, 5, ASRC | seuF(1),                       "ldur"});
      tbl.push_back('{11'b11111000000, 1'b0, 4, R2L | ASRC | seuF(1),                 "stur"});
      tbl.push_back('{11'b00010101010, 1'b0, 3, seuF(2) | PSRC | PCWR,                "b"});
      tbl.push_back('{11'b10110100101, 1'b1, 3, R2L | seuF(3) | aopF(4) | PSRC | PCWR, "cbz_z1"});
      tbl.push_back('{11'b10110100000, 1'b0, 3, R2L | seuF(3) | aopF(4),              "cbz_z0"});
      tbl.push_back('{11'b10110101000, 1'b1, 3, R2L | seuF(3) | aopF(4),              "cbnz_z1"});
      tbl.push_back('{11'b10110101111, 1'b0, 3, R2L | seuF(3) | aopF(4) | PSRC | PCWR, "cbnz_z0"});
`ifndef ILLEGAL_TRAP_EN
      tbl.push_back('{11'b11111000011, 1'b0, 2, 15'd0,                                "ldur_nearmiss"});
      tbl.push_back('{11'b11111111111, 1'b1, 2, 15'd0,                                "nop_ones"});
`endif

      rst = 1'b1; mem_ready = 1'b1; zero = 1'b1; opcode = 11'h7ff;
      repeat (2) @(posedge clk);
      #3;
      chk(act, 15'd0, "reset_outputs");
      @(posedge clk); #1;
      rst = 1'b0;

      // Directed table, memory always ready; latency measured to the next fetch.
      foreach (tbl[i]) begin
         opcode = tbl[i].op; zero = tbl[i].z; mem_ready = 1'b1;
         capIdx = (tbl[i].len == 2) ? 1 : 2;
         len = 0; cap = 'x;
         for (int c = 0; c < 20; c++) begin
            #2;
            if (c == capIdx) cap = act;
            if (c > 0 && ir_wr) begin len = c; break; end
            @(posedge clk); #1;
         end
         chk(cap, tbl[i].ex, {tbl[i].nm, "_out"});
         chk(15'(len), 15'(tbl[i].len), {tbl[i].nm, "_latency"});
      end

      // LDUR with three wait cycles in MEM, then a plain ADD with no waits.
      runInstr(11'b11111000010, 0, 3, "ldur_wait3");
      runInstr(11'b10001011000, 0, 0, "add_after_ldur");

      // Reset during a STUR memory wait.
      opcode = 11'b11111000000; zero = 1'b0; mem_ready = 1'b1;
      step(MRD | IRWR | PCWR, "stur_fetch");
      step(R2L, "stur_decode");
      step(R2L | ASRC | seuF(1), "stur_exec");
      mem_ready = 1'b0;
      step(MWR | R2L | ASRC | seuF(1), "stur_mem_wait0");
      step(MWR | R2L | ASRC | seuF(1), "stur_mem_wait1");
      rst = 1'b1; mem_ready = 1'b1;
      #2 chk(act, 15'd0, "rst_mid_mem");
      @(posedge clk); #3;
      chk(act, 15'd0, "rst_held");
      @(posedge clk); #1;
      rst = 1'b0; mem_ready = 1'b0;
      step(MRD, "post_rst_fetch");
      runInstr(11'b10101010000, 1, 0, "orr_after_rst");

      // Unknown opcode.
      opcode = 11'b00000000000; mem_ready = 1'b1;
      step(MRD | IRWR | PCWR, "nop_fetch");
      step(15'd0, "nop_decode");
`ifdef ILLEGAL_TRAP_EN
      for (int c = 0; c < 4; c++) begin
         mem_ready = 1'($urandom); zero = 1'($urandom); opcode = 11'($urandom);
         step(TRP, $sformatf("trap_hold%0d", c));
      end
      rst = 1'b1;
      #2 chk(act, 15'd0, "trap_rst");
      @(posedge clk); #1;
      rst = 1'b0; mem_ready = 1'b0;
`else
      mem_ready = 1'b0;
`endif
      step(MRD, "nop_back_fetch");

      // Random instruction stream with random memory waits, zero and off-DECODE opcodes.
      for (int n = 0; n < 150; n++) begin
         do begin
            j  = $urandom_range(0, 13);
            op = base[j] | 11'($urandom & ((1 << freeBits[j]) - 1));
`ifdef ILLEGAL_TRAP_EN
         end while (classify(op) == K_NOP);
`else
         end while (1'b0);
`endif
         runInstr(op, -1, -1, $sformatf("rnd%0d", n));
      end

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
